// File: rtl/shadow_scoreboard.sv
// shadow_scoreboard
//   Keeps a shadow copy of a memory region and checks the read data returned
//   by a DUT on NUM_PORTS independent response ports against it.  Writes seen
//   on the ports update the shadow copy with byte enables.  Errors are counted
//   per port.  The first error is captured, and the checker halts once the
//   total error count reaches HALT_THRESH.
//
// Ports
//   clk, rst          clock (rising edge); synchronous active-low reset
//   init_valid/idx/line/done
//                     preload one shadow line per strobe while in INIT;
//                     init_done moves the checker to RUN
//   read, write, resp per-port transaction qualifiers (bit p = port p)
//   address           per-port 32-bit byte address
//   wdata, mbe, rdata per-port write data, byte enables and DUT read data
//   err_count         per-port saturating 16-bit error counters
//   err_any           any counter nonzero
//   halted, state     checker state (0 INIT, 1 RUN, 2 HALT)
//   first_err_*       details of the first error since reset
module shadow_scoreboard #(
  parameter int          NUM_PORTS   = 2,
  parameter int          DATA_W      = 32,
  parameter int          LINE_W      = 256,
  parameter int          DEPTH       = 64,
  parameter logic [31:0] BASE_ADDR   = 32'h4000_0000,
  parameter int          HALT_THRESH = 16,
  localparam int         IDX_W       = $clog2(DEPTH),
  localparam int         PORT_W      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
  localparam int         BYTES       = DATA_W / 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          init_valid,
  input  logic [IDX_W-1:0]              init_idx,
  input  logic [LINE_W-1:0]             init_line,
  input  logic                          init_done,
  input  logic [NUM_PORTS-1:0]          read,
  input  logic [NUM_PORTS-1:0]          write,
  input  logic [NUM_PORTS-1:0]          resp,
  input  logic [32*NUM_PORTS-1:0]       address,
  input  logic [DATA_W*NUM_PORTS-1:0]   wdata,
  input  logic [BYTES*NUM_PORTS-1:0]    mbe,
  input  logic [DATA_W*NUM_PORTS-1:0]   rdata,
  output logic [16*NUM_PORTS-1:0]       err_count,
  output logic                          err_any,
  output logic                          halted,
  output logic [1:0]                    state,
  output logic                          first_err_valid,
  output logic [PORT_W-1:0]             first_err_port,
  output logic [31:0]                   first_err_addr,
  output logic [DATA_W-1:0]             first_err_exp,
  output logic [DATA_W-1:0]             first_err_got,
  output logic                          first_err_oor
);

  localparam int WPL    = LINE_W / DATA_W;
  localparam int NWORDS = DEPTH * WPL;
  localparam int WIDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int BSH    = $clog2(BYTES);
  // Size of the shadowed window in bytes; 33 bits so DEPTH*LINE_W/8 = 4 GiB fits.
  localparam logic [32:0] SPAN = 33'(DEPTH) * 33'(LINE_W / 8);

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t state_reg, state_next;

  // Shadow storage held as a flat word array: word index = line*WPL + word.
  // Every port must compare against the pre-edge contents in the resp cycle,
  // so reads are asynchronous (distributed RAM) rather than registered.
  logic [DATA_W-1:0] mem [NWORDS];

  logic run;
  assign run = (state_reg == S_RUN);

  logic [NUM_PORTS-1:0] err_hit;
  logic [NUM_PORTS-1:0] oor_hit;
  logic [NUM_PORTS-1:0] wr_en;
  logic [WIDX_W-1:0]    widx     [NUM_PORTS];
  logic [DATA_W-1:0]    exp_word [NUM_PORTS];
  logic [DATA_W-1:0]    got_word [NUM_PORTS];

  logic [15:0] cnt_reg  [NUM_PORTS];
  logic [15:0] cnt_next [NUM_PORTS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      logic [31:0]       off;
      logic              in_range;
      logic [DATA_W-1:0] stored;
      logic [DATA_W-1:0] rd_data;
      logic [DATA_W-1:0] wr_data;
      logic              hit;
      logic              oor;
      logic              we;
      logic [DATA_W-1:0] ex;
      logic [DATA_W-1:0] gt;

      // Unsigned wrap makes addresses below BASE_ADDR land far above SPAN.
      assign off      = address[gi*32 +: 32] - BASE_ADDR;
      assign in_range = ({1'b0, off} < SPAN);
      assign widx[gi] = WIDX_W'(off >> BSH);
      assign stored   = mem[widx[gi]];
      assign rd_data  = rdata[gi*DATA_W +: DATA_W];
      assign wr_data  = wdata[gi*DATA_W +: DATA_W];

      always_comb begin
        hit = 1'b0;
        oor = 1'b0;
        we  = 1'b0;
        ex  = '0;
        gt  = rd_data;
        if (run && resp[gi]) begin
          if (read[gi] && write[gi]) begin
            // Ambiguous direction: flagged, nothing written.
            hit = 1'b1;
          end else if ((read[gi] || write[gi]) && !in_range) begin
            hit = 1'b1;
            oor = 1'b1;
            // For a stray write the offending data is what the DUT wrote.
            if (write[gi]) gt = wr_data;
          end else if (read[gi]) begin
            ex  = stored;
            hit = (rd_data != stored);
          end else if (write[gi]) begin
            we = 1'b1;
          end
        end
      end

      assign err_hit[gi]  = hit;
      assign oor_hit[gi]  = oor;
      assign wr_en[gi]    = we;
      assign exp_word[gi] = ex;
      assign got_word[gi] = gt;
      assign err_count[gi*16 +: 16] = cnt_reg[gi];
    end
  endgenerate

  // Counter update, running total and nonzero detection.
  logic [31:0] err_sum;
  logic        any_next;

  always_comb begin
    err_sum  = '0;
    any_next = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      cnt_next[p] = cnt_reg[p];
      if (err_hit[p] && (cnt_reg[p] != 16'hFFFF)) cnt_next[p] = cnt_reg[p] + 16'd1;
      err_sum  = err_sum + 32'(cnt_next[p]);
      any_next = any_next | (cnt_next[p] != 16'd0);
    end
  end

  // First-error selection: scanning downward leaves the lowest erroring port.
  logic              fe_hit;
  logic [PORT_W-1:0] fe_port;
  logic [31:0]       fe_addr;
  logic [DATA_W-1:0] fe_exp;
  logic [DATA_W-1:0] fe_got;
  logic              fe_oor;

  always_comb begin
    fe_hit  = |err_hit;
    fe_port = '0;
    fe_addr = '0;
    fe_exp  = '0;
    fe_got  = '0;
    fe_oor  = 1'b0;
    for (int p = NUM_PORTS - 1; p >= 0; p--) begin
      if (err_hit[p]) begin
        fe_port = PORT_W'(p);
        fe_addr = address[p*32 +: 32];
        fe_exp  = exp_word[p];
        fe_got  = got_word[p];
        fe_oor  = oor_hit[p];
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_INIT: if (init_done) state_next = S_RUN;
      S_RUN: begin
        if ((HALT_THRESH != 0) && (err_sum >= 32'(HALT_THRESH))) state_next = S_HALT;
      end
      S_HALT:  state_next = S_HALT;
      default: state_next = S_INIT;
    endcase
  end

  logic              err_any_reg;
  logic              fe_valid_reg;
  logic [PORT_W-1:0] fe_port_reg;
  logic [31:0]       fe_addr_reg;
  logic [DATA_W-1:0] fe_exp_reg;
  logic [DATA_W-1:0] fe_got_reg;
  logic              fe_oor_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= S_INIT;
      for (int p = 0; p < NUM_PORTS; p++) cnt_reg[p] <= '0;
      err_any_reg  <= 1'b0;
      fe_valid_reg <= 1'b0;
      fe_port_reg  <= '0;
      fe_addr_reg  <= '0;
      fe_exp_reg   <= '0;
      fe_got_reg   <= '0;
      fe_oor_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      for (int p = 0; p < NUM_PORTS; p++) cnt_reg[p] <= cnt_next[p];
      err_any_reg <= any_next;
      // err_hit is only ever set in RUN, so no capture happens in INIT/HALT.
      if (!fe_valid_reg && fe_hit) begin
        fe_valid_reg <= 1'b1;
        fe_port_reg  <= fe_port;
        fe_addr_reg  <= fe_addr;
        fe_exp_reg   <= fe_exp;
        fe_got_reg   <= fe_got;
        fe_oor_reg   <= fe_oor;
      end
    end
  end

  // Shadow storage is not cleared by reset, but a reset cycle drops any
  // write that arrives with it.  Later ports are assigned last, so the
  // highest port index wins each overlapping byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      if ((state_reg == S_INIT) && init_valid) begin
        for (int w = 0; w < WPL; w++) begin
          mem[WIDX_W'(int'(init_idx) * WPL + w)] <= init_line[w*DATA_W +: DATA_W];
        end
      end
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (wr_en[p]) begin
          for (int b = 0; b < BYTES; b++) begin
            if (mbe[p*BYTES + b]) mem[widx[p]][b*8 +: 8] <= wdata[p*DATA_W + b*8 +: 8];
          end
        end
      end
    end
  end

  assign err_any         = err_any_reg;
  assign halted          = (state_reg == S_HALT);
  assign state           = state_reg;
  assign first_err_valid = fe_valid_reg;
  assign first_err_port  = fe_port_reg;
  assign first_err_addr  = fe_addr_reg;
  assign first_err_exp   = fe_exp_reg;
  assign first_err_got   = fe_got_reg;
  assign first_err_oor   = fe_oor_reg;

endmodule

// File: tb/tb_shadow_scoreboard.sv
// tb_shadow_scoreboard
//   Directed bench for shadow_scoreboard (2 ports, 32-bit words, 256-bit
//   lines, 64 lines, HALT_THRESH = 4).  Each step queues the expected
//   counter/state snapshot, clocks once, then pops and checks it.
module tb_shadow_scoreboard;

  logic        clk;
  logic        rst;
  logic        init_valid;
  logic [5:0]  init_idx;
  logic [255:0] init_line;
  logic        init_done;
  logic [1:0]  read;
  logic [1:0]  write;
  logic [1:0]  resp;
  logic [63:0] address;
  logic [63:0] wdata;
  logic [7:0]  mbe;
  logic [63:0] rdata;
  logic [31:0] err_count;
  logic        err_any;
  logic        halted;
  logic [1:0]  state;
  logic        first_err_valid;
  logic [0:0]  first_err_port;
  logic [31:0] first_err_addr;
  logic [31:0] first_err_exp;
  logic [31:0] first_err_got;
  logic        first_err_oor;

  shadow_scoreboard #(
    .NUM_PORTS(2), .DATA_W(32), .LINE_W(256), .DEPTH(64),
    .BASE_ADDR(32'h4000_0000), .HALT_THRESH(4)
  ) dut (
    .clk(clk), .rst(rst),
    .init_valid(init_valid), .init_idx(init_idx), .init_line(init_line), .init_done(init_done),
    .read(read), .write(write), .resp(resp), .address(address),
    .wdata(wdata), .mbe(mbe), .rdata(rdata),
    .err_count(err_count), .err_any(err_any), .halted(halted), .state(state),
    .first_err_valid(first_err_valid), .first_err_port(first_err_port),
    .first_err_addr(first_err_addr), .first_err_exp(first_err_exp),
    .first_err_got(first_err_got), .first_err_oor(first_err_oor)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [15:0] c0;
    logic [15:0] c1;
    logic        any;
    logic [1:0]  st;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   m_cnt [2];
  logic [1:0] m_state;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s got=%08h exp=%08h", tag, obs, expv);
    end
  endtask

  task automatic idle();
    resp = '0; read = '0; write = '0; address = '0;
    wdata = '0; mbe = '0; rdata = '0;
    init_valid = 1'b0; init_done = 1'b0; init_idx = '0; init_line = '0;
  endtask

  task automatic port_op(input int p, input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] be, input logic [31:0] rdat);
    resp[p] = 1'b1;
    read[p] = rd;
    write[p] = wr;
    address[p*32 +: 32] = a;
    wdata[p*32 +: 32] = wd;
    mbe[p*4 +: 4] = be;
    rdata[p*32 +: 32] = rdat;
  endtask

  task automatic step(input string tag);
    exp_t e;
    e.tag = tag;
    e.c0  = 16'(m_cnt[0]);
    e.c1  = 16'(m_cnt[1]);
    e.any = (m_cnt[0] != 0) || (m_cnt[1] != 0);
    e.st  = m_state;
    sb.push_back(e);
    @(posedge clk);
    #1;
    idle();
    e = sb.pop_front();
    chk({e.tag, ":cnt0"}, 32'(err_count[15:0]), 32'(e.c0));
    chk({e.tag, ":cnt1"}, 32'(err_count[31:16]), 32'(e.c1));
    chk({e.tag, ":any"}, 32'(err_any), 32'(e.any));
    chk({e.tag, ":state"}, 32'(state), 32'(e.st));
    chk({e.tag, ":halted"}, 32'(halted), 32'(e.st == 2'd2));
    $display("step %-16s cnt0=%0d cnt1=%0d any=%0b state=%0d", e.tag,
             err_count[15:0], err_count[31:16], err_any, state);
  endtask

  task automatic chk_first(input string tag, input logic v, input logic [0:0] p, input logic [31:0] a,
                           input logic [31:0] ex, input logic [31:0] gt, input logic o);
    chk({tag, ":fe_valid"}, 32'(first_err_valid), 32'(v));
    chk({tag, ":fe_port"}, 32'(first_err_port), 32'(p));
    chk({tag, ":fe_addr"}, first_err_addr, a);
    chk({tag, ":fe_exp"}, first_err_exp, ex);
    chk({tag, ":fe_got"}, first_err_got, gt);
    chk({tag, ":fe_oor"}, 32'(first_err_oor), 32'(o));
  endtask

  initial begin
    rst = 1'b0;
    idle();
    m_cnt[0] = 0; m_cnt[1] = 0; m_state = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    step("reset");
    chk_first("reset", 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    rst = 1'b1;

    // Preload line 0 (word 0 = DEADBEEF, rest zero)
    init_valid = 1'b1; init_idx = 6'd0; init_line = '0; init_line[31:0] = 32'hDEADBEEF;
    step("preload0");

    // Line 1 written in the same cycle as init_done
    init_valid = 1'b1; init_idx = 6'd1; init_done = 1'b1;
    for (int w = 0; w < 8; w++) init_line[w*32 +: 32] = 32'h5555_0000 + 32'(w);
    m_state = 2'd1;
    step("init_done");

    // Matching read; init_valid in RUN must be ignored
    port_op(0, 1'b1, 1'b0, 32'h4000_0000, 32'h0, 4'h0, 32'hDEADBEEF);
    init_valid = 1'b1; init_idx = 6'd0; init_line = '1;
    step("rd_preload");

    port_op(1, 1'b1, 1'b0, 32'h4000_0024, 32'h0, 4'h0, 32'h5555_0001);
    step("rd_line1");

    // Byte-masked write then mismatching read on port 1
    port_op(1, 1'b0, 1'b1, 32'h4000_0004, 32'h1122_3344, 4'b0101, 32'h0);
    step("wr_mbe");
    port_op(1, 1'b1, 1'b0, 32'h4000_0004, 32'h0, 4'h0, 32'h0022_0045);
    port_op(0, 1'b1, 1'b0, 32'h4000_0006, 32'h0, 4'h0, 32'h0022_0044);
    m_cnt[1] = 1;
    step("rd_mismatch");
    chk_first("first_p1", 1'b1, 1'b1, 32'h4000_0004, 32'h0022_0044, 32'h0022_0045, 1'b0);

    // Colliding writes: port 1 wins; same-cycle read sees old value
    port_op(0, 1'b0, 1'b1, 32'h4000_0008, 32'hAAAA_AAAA, 4'hF, 32'h0);
    port_op(1, 1'b0, 1'b1, 32'h4000_0008, 32'hBBBB_BBBB, 4'hF, 32'h0);
    step("wr_collide");
    port_op(0, 1'b1, 1'b0, 32'h4000_0008, 32'h0, 4'h0, 32'hBBBB_BBBB);
    port_op(1, 1'b0, 1'b1, 32'h4000_0008, 32'hCCCC_CCCC, 4'hF, 32'h0);
    step("rd_old_wr_new");
    port_op(0, 1'b1, 1'b0, 32'h4000_0008, 32'h0, 4'h0, 32'hCCCC_CCCC);
    step("rd_new");

    // Below the window
    port_op(0, 1'b1, 1'b0, 32'h3FFF_FFFC, 32'h0, 4'h0, 32'h0);
    m_cnt[0] = 1;
    step("oor_low");
    chk_first("first_held", 1'b1, 1'b1, 32'h4000_0004, 32'h0022_0044, 32'h0022_0045, 1'b0);

    // Last word of the window is in range, next byte is not
    port_op(1, 1'b0, 1'b1, 32'h4000_07FC, 32'h1234_5678, 4'hF, 32'h0);
    step("wr_top");
    port_op(1, 1'b1, 1'b0, 32'h4000_07FC, 32'h0, 4'h0, 32'h1234_5678);
    step("rd_top");
    port_op(1, 1'b0, 1'b1, 32'h4000_0800, 32'h0, 4'hF, 32'h0);
    m_cnt[1] = 2;
    step("oor_high");

    // mbe = 0 write changes nothing
    port_op(0, 1'b0, 1'b1, 32'h4000_07FC, 32'hFFFF_FFFF, 4'h0, 32'h0);
    step("wr_mbe0");
    port_op(0, 1'b1, 1'b0, 32'h4000_07FC, 32'h0, 4'h0, 32'h1234_5678);
    step("rd_mbe0");

    // Reset with a write pending: write discarded, outputs cleared
    rst = 1'b0;
    port_op(0, 1'b0, 1'b1, 32'h4000_0000, 32'h0, 4'hF, 32'h0);
    m_cnt[0] = 0; m_cnt[1] = 0; m_state = 2'd0;
    step("reset_mid");
    chk_first("after_reset", 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    rst = 1'b1;
    init_done = 1'b1;
    m_state = 2'd1;
    step("reinit");
    port_op(0, 1'b1, 1'b0, 32'h4000_0000, 32'h0, 4'h0, 32'hDEADBEEF);
    port_op(1, 1'b1, 1'b0, 32'h4000_0008, 32'h0, 4'h0, 32'hCCCC_CCCC);
    step("rd_kept");

    // Simultaneous errors: lowest port captured
    port_op(0, 1'b1, 1'b0, 32'h4000_0000, 32'h0, 4'h0, 32'h0);
    port_op(1, 1'b1, 1'b0, 32'h4000_0000, 32'h0, 4'h0, 32'h1);
    m_cnt[0] = 1; m_cnt[1] = 1;
    step("two_err");
    chk_first("first_p0", 1'b1, 1'b0, 32'h4000_0000, 32'hDEADBEEF, 32'h0, 1'b0);

    // read and write both set
    port_op(1, 1'b1, 1'b1, 32'h4000_0010, 32'h0, 4'hF, 32'h7);
    m_cnt[1] = 2;
    step("rd_wr_both");

    // Fourth error reaches the threshold
    port_op(0, 1'b1, 1'b0, 32'h4000_0024, 32'h0, 4'h0, 32'h0);
    m_cnt[0] = 2; m_state = 2'd2;
    step("fourth_err");

    // Nothing counted once halted
    port_op(0, 1'b1, 1'b0, 32'h4000_0024, 32'h0, 4'h0, 32'h0);
    port_op(1, 1'b1, 1'b0, 32'h4000_0024, 32'h0, 4'h0, 32'h0);
    step("after_halt");
    chk_first("first_halt", 1'b1, 1'b0, 32'h4000_0000, 32'hDEADBEEF, 32'h0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shadow_scoreboard.md
SHADOW_SCOREBOARD -- requirements
Module: shadow_scoreboard

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2, number of independent memory-response ports checked.
REQ-002 SHALL have parameter DATA_W, default 32, word width; a multiple of 8.
REQ-003 SHALL have parameter LINE_W, default 256, shadow line width; LINE_W/DATA_W a power of 2.
REQ-004 SHALL have parameter DEPTH, default 64, number of shadow lines; a power of 2.
REQ-005 SHALL have parameter BASE_ADDR, default 32'h4000_0000, byte address of line 0.
REQ-006 SHALL have parameter HALT_THRESH, default 16, total error count that forces HALT.
REQ-007 SHALL have ports: clk input 1 (clock, rising edge); rst input 1 (reset, synchronous, active-low).
REQ-008 SHALL have ports: init_valid input 1 (preload strobe); init_idx input log2(DEPTH) (line index); init_line input LINE_W (line data); init_done input 1 (preload complete).
REQ-009 SHALL have ports, one slice per port p: read input NUM_PORTS; write input NUM_PORTS; resp input NUM_PORTS; address input 32*NUM_PORTS (byte address); wdata input DATA_W*NUM_PORTS; mbe input (DATA_W/8)*NUM_PORTS; rdata input DATA_W*NUM_PORTS (DUT-returned data).
REQ-010 SHALL have ports: err_count output 16*NUM_PORTS (per-port errors); err_any output 1; halted output 1; state output 2.
REQ-011 SHALL have ports: first_err_valid output 1; first_err_port output log2(NUM_PORTS) (min width 1); first_err_addr output 32; first_err_exp output DATA_W; first_err_got output DATA_W; first_err_oor output 1 (out-of-range flag).

Function
REQ-012 SHALL implement state machine INIT(2'd0), RUN(2'd1), HALT(2'd2); state output is the encoding.
REQ-013 INIT: init_valid writes init_line into line init_idx at the clock edge; port traffic ignored, no counting.
REQ-014 INIT->RUN on the edge where init_done=1; an init_valid in that same cycle is still written.
REQ-015 RUN: init_valid ignored; a port transaction is a cycle with resp[p]=1 and exactly one of read[p]/write[p]=1; read=write=1 counts as a port error (exp=0, got=rdata).
REQ-016 Word select: line = (address-BASE_ADDR)/(LINE_W/8), word = address bits above log2(DATA_W/8) within line; low byte-offset bits ignored.
REQ-017 Address in range iff 0 <= address-BASE_ADDR < DEPTH*LINE_W/8 (unsigned 32-bit subtract); otherwise out-of-range.
REQ-018 Read check: mismatch when rdata[p] != stored word; mismatch increments err_count[p] at the next edge.
REQ-019 Write: bytes with mbe bit set replaced by corresponding wdata bytes at the next edge; mbe=0 is a legal no-op.
REQ-020 Out-of-range read or write: counted as a port error, write dropped, exp=0, first_err_oor=1 if captured.
REQ-021 Same-cycle ordering: all reads compare against pre-edge contents; overlapping byte writes from several ports resolve with highest port index winning per byte.
REQ-022 err_count[p] saturates at 16'hFFFF; several ports may increment in one cycle.
REQ-023 First-error capture: on the first error edge since reset, latch port, address, exp, got, oor and set first_err_valid; lowest port index wins on simultaneous errors; held until reset.
REQ-024 err_any = OR of all err_count nonzero, registered with counters.
REQ-025 RUN->HALT on the edge where the sum of all err_count after update >= HALT_THRESH; HALT_THRESH=0 disables halting.
REQ-026 HALT: no further counting, writes or captures; halted=1; exit only via reset.
REQ-027 Latency: errors, counters, capture and memory updates visible exactly one cycle after the resp cycle.

Reset
REQ-028 On rst=0 at an edge: state=INIT, err_count=0, err_any=0, halted=0, first_err_* =0; shadow contents unchanged.
REQ-029 Reset mid-transaction discards that cycle's transaction entirely.

Verification
REQ-030 Preload line 0 word 0 = 32'hDEADBEEF, init_done, port0 read 0x4000_0000 rdata DEADBEEF -> err_count[0]=0, err_any=0.
REQ-031 Port1 write 0x4000_0004 wdata 32'h11223344 mbe 4'b0101, then read expects 32'h00220044 (from zero line); rdata 32'h00220045 -> err_count[1]=1, first_err_port=1, exp 00220044, got 00220045.
REQ-032 Same cycle: port0 and port1 write 0x4000_0008 mbe 4'hF, data AAAAAAAA/BBBBBBBB, plus port0 read of same address in the next cycle -> BBBBBBBB expected; a same-cycle read sees old value.
REQ-033 Port0 read 0x3FFF_FFFC -> err_count[0]+1, first_err_oor=1, exp=0.
REQ-034 HALT_THRESH=4, four mismatching reads -> state=HALT after fourth, halted=1; fifth mismatch leaves counts at 4.
REQ-035 Errors pending, rst=0 for one cycle -> all outputs zero, state=INIT, preloaded data still readable after init_done.
